rgb_led_pwm_ctrl: RTL and testbench

RGB_LED_PWM_CTRL -- requirements
Module: rgb_led_pwm_ctrl

---
 rtl/rgb_led_pkg.sv | 27 ++
 rtl/rgb_led_timebase.sv | 93 +++++++++
 rtl/rgb_led_pwm_ctrl.sv | 129 ++++++++++++
 tb/tb_rgb_led_pwm_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_led_pkg.sv
// Shared encodings for the RGB LED PWM controller: per-LED modes and register offsets.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package rgb_led_pkg;

    // Per-LED operating modes, taken from wr_data[1:0] on a mode-register write
    localparam logic [1:0] MODE_OFF     = 2'd0;
    localparam logic [1:0] MODE_STATIC  = 2'd1;
    localparam logic [1:0] MODE_BLINK   = 2'd2;
    localparam logic [1:0] MODE_BREATHE = 2'd3;

    // Register offsets within one LED's 4-entry address window
    localparam logic [1:0] REG_R    = 2'd0;
    localparam logic [1:0] REG_G    = 2'd1;
    localparam logic [1:0] REG_B    = 2'd2;
    localparam logic [1:0] REG_MODE = 2'd3;

    // Duty channel index (0=R, 1=G, 2=B) to its register offset
    function automatic logic [1:0] chan_reg(input int chan);
        logic [1:0] r;
        r = REG_B;
        if (chan == 0) r = REG_R;
        else if (chan == 1) r = REG_G;
        return r;
    endfunction

endpackage

// File: rtl/rgb_led_timebase.sv
// Shared timebase: prescaler, PWM counter, period strobe, blink phase and breathe level.
// Latency: period_stb is decoded combinationally from the counters; all state steps on ck.
// Backpressure: none, free-running from reset release.
module rgb_led_timebase #(
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 98,
    parameter int BLINK_PERIODS = 250
) (
    input  logic                ck,
    input  logic                rst_n,
    output logic [PWM_BITS-1:0] pwm_cnt,
    output logic                period_stb,
    output logic                blink_on,
    output logic [PWM_BITS-1:0] level
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [BL_W-1:0]     BL_LAST  = BL_W'(BLINK_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] PWM_MAX  = {PWM_BITS{1'b1}};

    logic [PS_W-1:0]     presc_q, presc_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BL_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                blink_on_q, blink_on_d;
    logic [PWM_BITS-1:0] level_q, level_d;
    logic                dir_up_q, dir_up_d;
    logic                step;
    logic                stb;

    // Next-state for prescaler, PWM counter, blink phase and breathe ramp
    always_comb begin
        step        = (presc_q == PS_LAST);
        presc_d     = step ? '0 : presc_q + PS_W'(1);
        pwm_cnt_d   = step ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        stb         = step && (pwm_cnt_q == PWM_MAX);
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        level_d     = level_q;
        dir_up_d    = dir_up_q;
        if (stb) begin
            if (blink_cnt_q == BL_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BL_W'(1);
            end
            // Turning around at an endpoint steps away immediately, so each
            // endpoint level is seen for exactly one period
            if (dir_up_q) begin
                if (level_q == PWM_MAX) begin
                    dir_up_d = 1'b0;
                    level_d  = level_q - PWM_BITS'(1);
                end else begin
                    level_d  = level_q + PWM_BITS'(1);
                end
            end else begin
                if (level_q == '0) begin
                    dir_up_d = 1'b1;
                    level_d  = level_q + PWM_BITS'(1);
                end else begin
                    level_d  = level_q - PWM_BITS'(1);
                end
            end
        end
    end

    // Timebase state registers
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            pwm_cnt_q   <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            level_q     <= '0;
            dir_up_q    <= 1'b1;
        end else begin
            presc_q     <= presc_d;
            pwm_cnt_q   <= pwm_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            level_q     <= level_d;
            dir_up_q    <= dir_up_d;
        end
    end

    assign pwm_cnt    = pwm_cnt_q;
    assign period_stb = stb;
    assign blink_on   = blink_on_q;
    assign level      = level_q;

endmodule

// File: rtl/rgb_led_pwm_ctrl.sv
// Multi-LED RGB PWM driver with shadowed duty/mode registers and blink/breathe effects.
// Latency: led_rgb is registered one ck after the pwm_cnt compare; writes go live at period end.
// Backpressure: none, one register write accepted every cycle.
module rgb_led_pwm_ctrl
    import rgb_led_pkg::*;
#(
    parameter int NUM_LEDS      = 4,
    parameter int PWM_BITS      = 8,
    parameter int PRESCALE      = 98,
    parameter int BLINK_PERIODS = 250,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic                  ck,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [4:0]            wr_addr,
    input  logic [PWM_BITS-1:0]   wr_data,
    output logic [3*NUM_LEDS-1:0] led_rgb,
    output logic                  period_stb
);

    localparam int   NUM_CH = 3 * NUM_LEDS;
    localparam int   PW2    = 2 * PWM_BITS;
    localparam logic INACT  = (ACTIVE_LOW != 0);

    logic [PWM_BITS-1:0] pwm_cnt;
    logic                stb;
    logic                blink_on;
    logic [PWM_BITS-1:0] level;

    // Duty registers are flattened as index led*3 + chan (chan 0=R, 1=G, 2=B)
    logic [PWM_BITS-1:0] sh_duty_q  [NUM_CH];
    logic [PWM_BITS-1:0] sh_duty_d  [NUM_CH];
    logic [PWM_BITS-1:0] act_duty_q [NUM_CH];
    logic [PWM_BITS-1:0] act_duty_d [NUM_CH];
    logic [1:0]          sh_mode_q  [NUM_LEDS];
    logic [1:0]          sh_mode_d  [NUM_LEDS];
    logic [1:0]          act_mode_q [NUM_LEDS];
    logic [1:0]          act_mode_d [NUM_LEDS];

    logic [PW2-1:0]      prod       [NUM_CH];
    logic [PWM_BITS-1:0] eff_duty   [NUM_CH];
    logic [NUM_CH-1:0]   led_rgb_q, led_rgb_d;

    logic                wr_hit;
    logic [2:0]          wr_led;
    logic [1:0]          wr_reg;

    rgb_led_timebase #(
        .PWM_BITS      (PWM_BITS),
        .PRESCALE      (PRESCALE),
        .BLINK_PERIODS (BLINK_PERIODS)
    ) u_timebase (
        .ck         (ck),
        .rst_n      (rst_n),
        .pwm_cnt    (pwm_cnt),
        .period_stb (stb),
        .blink_on   (blink_on),
        .level      (level)
    );

    // Register writes into shadows; shadows (including a same-cycle write) go live on period_stb
    always_comb begin
        wr_hit = wr_en && (32'(wr_addr) < 32'(4 * NUM_LEDS));
        wr_led = wr_addr[4:2];
        wr_reg = wr_addr[1:0];
        for (int l = 0; l < NUM_LEDS; l++) begin
            for (int c = 0; c < 3; c++) begin
                sh_duty_d[l*3+c] = sh_duty_q[l*3+c];
                if (wr_hit && (wr_led == 3'(l)) && (wr_reg == chan_reg(c))) begin
                    sh_duty_d[l*3+c] = wr_data;
                end
                act_duty_d[l*3+c] = stb ? sh_duty_d[l*3+c] : act_duty_q[l*3+c];
            end
            sh_mode_d[l] = sh_mode_q[l];
            if (wr_hit && (wr_led == 3'(l)) && (wr_reg == REG_MODE)) begin
                sh_mode_d[l] = wr_data[1:0];
            end
            act_mode_d[l] = stb ? sh_mode_d[l] : act_mode_q[l];
        end
    end

    // Effective duty per channel from mode, then the PWM compare feeding the output flops
    always_comb begin
        for (int l = 0; l < NUM_LEDS; l++) begin
            for (int c = 0; c < 3; c++) begin
                // Full-width product; only the shifted result is truncated
                prod[l*3+c]     = PW2'(act_duty_q[l*3+c]) * PW2'(level);
                eff_duty[l*3+c] = '0;
                case (act_mode_q[l])
                    MODE_STATIC:  eff_duty[l*3+c] = act_duty_q[l*3+c];
                    MODE_BLINK:   eff_duty[l*3+c] = blink_on ? act_duty_q[l*3+c] : '0;
                    MODE_BREATHE: eff_duty[l*3+c] = prod[l*3+c][PW2-1:PWM_BITS];
                    default:      eff_duty[l*3+c] = '0;
                endcase
                led_rgb_d[l*3+2-c] = (pwm_cnt < eff_duty[l*3+c]) ? ~INACT : INACT;
            end
        end
    end

    // Shadow/active register file and registered LED outputs
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_duty_q[i]  <= '0;
                act_duty_q[i] <= '0;
            end
            for (int l = 0; l < NUM_LEDS; l++) begin
                sh_mode_q[l]  <= MODE_OFF;
                act_mode_q[l] <= MODE_OFF;
            end
            led_rgb_q <= {NUM_CH{INACT}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                sh_duty_q[i]  <= sh_duty_d[i];
                act_duty_q[i] <= act_duty_d[i];
            end
            for (int l = 0; l < NUM_LEDS; l++) begin
                sh_mode_q[l]  <= sh_mode_d[l];
                act_mode_q[l] <= act_mode_d[l];
            end
            led_rgb_q <= led_rgb_d;
        end
    end

    assign led_rgb    = led_rgb_q;
    assign period_stb = stb;

endmodule

// File: tb/tb_rgb_led_pwm_ctrl.sv
// Directed testbench for rgb_led_pwm_ctrl with PRESCALE=1, PWM_BITS=8, NUM_LEDS=4.
// A second, ACTIVE_LOW instance sees identical stimulus and must stay the inverse of the first.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_rgb_led_pwm_ctrl;

    logic        ck      = 1'b0;
    logic        rst_n   = 1'b1;
    logic        wr_en   = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [11:0] led_rgb, led_rgb_al;
    logic        period_stb, period_stb_al;

    int checks = 0;
    int errors = 0;
    int cnt [12];
    int stb_at;
    int inv_bad;

    always #5 ck = ~ck;

    rgb_led_pwm_ctrl #(
        .NUM_LEDS(4), .PWM_BITS(8), .PRESCALE(1), .BLINK_PERIODS(2), .ACTIVE_LOW(0)
    ) dut (
        .ck(ck), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .led_rgb(led_rgb), .period_stb(period_stb)
    );

    rgb_led_pwm_ctrl #(
        .NUM_LEDS(4), .PWM_BITS(8), .PRESCALE(1), .BLINK_PERIODS(2), .ACTIVE_LOW(1)
    ) dut_al (
        .ck(ck), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .led_rgb(led_rgb_al), .period_stb(period_stb_al)
    );

    task automatic write_reg(input logic [4:0] a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge ck);
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        @(negedge ck);
        rst_n = 1'b0;
        repeat (3) @(negedge ck);
        rst_n = 1'b1;
    endtask

    // Returns at the falling edge of the next period_stb cycle
    task automatic wait_stb(input string tag);
        bit found = 1'b0;
        for (int n = 0; n < 600 && !found; n++) begin
            @(negedge ck);
            if (period_stb === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL %s: period_stb not seen within 600 cycles", tag);
        end
    endtask

    // Called at the release edge; the release cycle holds pwm_cnt=0, so the strobe
    // (pwm_cnt=255) is seen 255 falling edges later, i.e. in the 256th cycle
    task automatic check_first_stb(input string tag);
        int  n     = 0;
        bit  found = 1'b0;
        while (!found && n < 600) begin
            @(negedge ck);
            n++;
            if (period_stb === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || n != 255) begin
            errors++;
            $display("FAIL %s: first period_stb after %0d cycles, required 255", tag, n);
        end
    endtask

    // Starting one cycle after a period_stb, samples the 256 output cycles of that period
    task automatic measure_period();
        for (int b = 0; b < 12; b++) cnt[b] = 0;
        stb_at  = -1;
        inv_bad = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge ck);
            for (int b = 0; b < 12; b++) if (led_rgb[b] === 1'b1) cnt[b]++;
            if (period_stb === 1'b1) stb_at = i;
            if (led_rgb_al !== ~led_rgb) inv_bad++;
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge ck);
        checks++;
        if (led_rgb !== 12'h000) begin
            errors++; $display("FAIL reset_led: got %h, required 000", led_rgb);
        end
        checks++;
        if (led_rgb_al !== 12'hFFF) begin
            errors++; $display("FAIL reset_led_al: got %h, required fff", led_rgb_al);
        end
        checks++;
        if (period_stb !== 1'b0) begin
            errors++; $display("FAIL reset_stb: got %b, required 0", period_stb);
        end
        rst_n = 1'b1;
        check_first_stb("reset_first_stb");
    endtask

    task automatic test_invalid_addr();
        write_reg(5'd3, 8'd1);          // LED0 STATIC, all duties still 0
        write_reg(5'd16, 8'hFF);
        write_reg(5'd17, 8'hFF);
        write_reg(5'd18, 8'hFF);
        write_reg(5'd19, 8'h03);
        wait_stb("inv_align");
        @(negedge ck);
        measure_period();
        checks++;
        if (cnt[2] + cnt[1] + cnt[0] != 0) begin
            errors++; $display("FAIL inv_led0: high cycles %0d, required 0", cnt[2] + cnt[1] + cnt[0]);
        end
        checks++;
        if (inv_bad != 0 || led_rgb_al !== 12'hFFF) begin
            errors++; $display("FAIL inv_active_low: led_al %h with %0d bad cycles, required fff", led_rgb_al, inv_bad);
        end
    endtask

    task automatic test_static();
        write_reg(5'd0, 8'd64);         // LED0 R
        write_reg(5'd3, 8'd1);
        write_reg(5'd9, 8'd10);         // LED2 G
        write_reg(5'd11, 8'd1);
        wait_stb("static_align");
        @(negedge ck);
        measure_period();
        checks++;
        if (cnt[2] != 64) begin errors++; $display("FAIL static_r: %0d high, required 64", cnt[2]); end
        checks++;
        if (cnt[1] != 0 || cnt[0] != 0) begin
            errors++; $display("FAIL static_gb: G %0d B %0d, required 0 0", cnt[1], cnt[0]);
        end
        checks++;
        if (cnt[7] != 10 || cnt[8] != 0 || cnt[6] != 0) begin
            errors++; $display("FAIL static_led2: R %0d G %0d B %0d, required 0 10 0", cnt[8], cnt[7], cnt[6]);
        end
        checks++;
        if (stb_at != 254) begin errors++; $display("FAIL static_stb_pos: %0d, required 254", stb_at); end
        checks++;
        if (inv_bad != 0) begin errors++; $display("FAIL static_active_low: %0d bad cycles, required 0", inv_bad); end
        measure_period();
        checks++;
        if (cnt[2] != 64) begin errors++; $display("FAIL static_r_2nd: %0d high, required 64", cnt[2]); end
    endtask

    // Entered one cycle after a strobe with R=64 active; new duty written at pwm_cnt=100
    task automatic test_mid_update();
        int r = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge ck);
            if (led_rgb[2] === 1'b1) r++;
            if (i == 99) begin
                wr_en = 1'b1; wr_addr = 5'd0; wr_data = 8'd200;
            end else begin
                wr_en = 1'b0;
            end
        end
        checks++;
        if (r != 64) begin errors++; $display("FAIL mid_keep: %0d high, required 64", r); end
        measure_period();
        checks++;
        if (cnt[2] != 200) begin errors++; $display("FAIL mid_next: %0d high, required 200", cnt[2]); end
        checks++;
        if (cnt[7] != 10) begin errors++; $display("FAIL mid_led2: %0d high, required 10", cnt[7]); end
    endtask

    task automatic test_back_to_back();
        wait_stb("b2b_align");
        write_reg(5'd0, 8'd30);         // lands in the strobe cycle itself
        measure_period();
        checks++;
        if (cnt[2] != 30) begin errors++; $display("FAIL b2b_same_cycle: %0d high, required 30", cnt[2]); end
    endtask

    task automatic test_reset_mid();
        write_reg(5'd0, 8'd200);
        wait_stb("rmid_align");
        @(negedge ck);
        repeat (50) @(negedge ck);
        checks++;
        if (led_rgb[2] !== 1'b1) begin errors++; $display("FAIL rmid_pre: R %b, required 1", led_rgb[2]); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (led_rgb !== 12'h000 || period_stb !== 1'b0) begin
            errors++; $display("FAIL rmid_async: led %h stb %b, required 000 0", led_rgb, period_stb);
        end
        checks++;
        if (led_rgb_al !== 12'hFFF) begin errors++; $display("FAIL rmid_async_al: %h, required fff", led_rgb_al); end
        repeat (2) @(negedge ck);
        rst_n = 1'b1;
        check_first_stb("rmid_first_stb");
        @(negedge ck);
        measure_period();
        checks++;
        if (cnt[2] + cnt[7] != 0) begin
            errors++; $display("FAIL rmid_off: R0 %0d G2 %0d, required 0 0", cnt[2], cnt[7]);
        end
    endtask

    task automatic test_blink();
        int exp_hi [6] = '{128, 0, 0, 128, 128, 0};
        do_reset();
        write_reg(5'd0, 8'd128);
        write_reg(5'd3, 8'd2);
        wait_stb("blink_align");
        @(negedge ck);
        for (int p = 0; p < 6; p++) begin
            measure_period();
            checks++;
            if (cnt[2] != exp_hi[p]) begin
                errors++; $display("FAIL blink_p%0d: %0d high, required %0d", p + 1, cnt[2], exp_hi[p]);
            end
        end
    endtask

    task automatic test_breathe();
        int lvl;
        int exp_hi;
        do_reset();
        write_reg(5'd0, 8'd255);
        write_reg(5'd3, 8'd3);
        wait_stb("breathe_align");
        @(negedge ck);
        for (int k = 1; k <= 258; k++) begin
            measure_period();
            lvl    = (k <= 255) ? k : 510 - k;
            exp_hi = (255 * lvl) >> 8;
            checks++;
            if (cnt[2] != exp_hi) begin
                errors++; $display("FAIL breathe_k%0d: %0d high, required %0d", k, cnt[2], exp_hi);
            end
        end
    endtask

    initial begin
        test_reset();
        test_invalid_addr();
        test_static();
        test_mid_update();
        test_back_to_back();
        test_reset_mid();
        test_blink();
        test_breathe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
